// File: rtl/cpu_mesi_requester.sv
// cpu_mesi_requester: processor-side MESI controller for one private cache.
// Decodes CPU load/store requests against the current line state and either
// completes locally (hit / silent upgrade) or arbitrates for the shared bus,
// optionally writing back a dirty victim first, then commits the new state.
//
// Optional feature macro: MESI_SILENT_UPGRADE_EN
//   defined     : store hit on E upgrades to M locally.
//   not defined : store hit on E issues invalidate on the bus, like S.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cpu_req_i, cpu_we_i    CPU request valid / store(1) vs load(0)
//   hit_i, status_q_i      tag match / current (or victim) line state
//   bus_gnt_i, bus_done_i  arbiter grant / transaction completion
//   bus_shared_i           another cache holds the line (at done)
//   cpu_ready_o            one-cycle completion pulse
//   bus_req_o, message_o   bus request / bus message (NA when idle)
//   wb_o                   current bus transaction is a victim write-back
//   status_we_o, status_n_o  line-state write strobe / new state
// Encodings: state I=00 M=01 S=10 E=11; message NA=00 INV=01 WM=10 RM=11.
module cpu_mesi_requester #(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned MSG_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cpu_req_i,
  input  logic               cpu_we_i,
  input  logic               hit_i,
  input  logic [STATE_W-1:0] status_q_i,
  input  logic               bus_gnt_i,
  input  logic               bus_done_i,
  input  logic               bus_shared_i,
  output logic               cpu_ready_o,
  output logic               bus_req_o,
  output logic [MSG_W-1:0]   message_o,
  output logic               wb_o,
  output logic               status_we_o,
  output logic [STATE_W-1:0] status_n_o
);

  localparam logic [STATE_W-1:0] ST_I = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_M = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_S = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_E = STATE_W'(3);

  localparam logic [MSG_W-1:0] MSG_NA  = MSG_W'(0);
  localparam logic [MSG_W-1:0] MSG_INV = MSG_W'(1);
  localparam logic [MSG_W-1:0] MSG_WM  = MSG_W'(2);
  localparam logic [MSG_W-1:0] MSG_RM  = MSG_W'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB_WB = 3'd1,
    S_BUS_WB = 3'd2,
    S_ARB    = 3'd3,
    S_BUS    = 3'd4,
    S_RESP   = 3'd5
  } fsm_e;

  fsm_e               state_q, state_d;
  logic [MSG_W-1:0]   msg_q, msg_d;        // pending coherence message
  logic               bus_req_d, wb_d, ready_d, status_we_d;
  logic [MSG_W-1:0]   message_d;
  logic [STATE_W-1:0] status_n_d;
  logic               miss;
  logic [STATE_W-1:0] fill_state;

  // A hit on an invalid line is a miss whose victim is that (I) line.
  assign miss = !hit_i || (status_q_i == ST_I);

  // Final state on completion: only a read miss looks at the shared line.
  assign fill_state = (msg_q == MSG_RM) ? (bus_shared_i ? ST_S : ST_E) : ST_M;

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      msg_q       <= MSG_NA;
      cpu_ready_o <= 1'b0;
      bus_req_o   <= 1'b0;
      message_o   <= MSG_NA;
      wb_o        <= 1'b0;
      status_we_o <= 1'b0;
      status_n_o  <= ST_I;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      cpu_ready_o <= ready_d;
      bus_req_o   <= bus_req_d;
      message_o   <= message_d;
      wb_o        <= wb_d;
      status_we_o <= status_we_d;
      status_n_o  <= status_n_d;
    end
  end

  // Next state and next registered output values.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    status_we_d = 1'b0;
    status_n_d  = ST_I;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          if (miss) begin
            msg_d   = cpu_we_i ? MSG_WM : MSG_RM;
            state_d = (status_q_i == ST_M) ? S_ARB_WB : S_ARB;
          end else if (!cpu_we_i || (status_q_i == ST_M)) begin
            state_d = S_RESP;
`ifdef MESI_SILENT_UPGRADE_EN
          end else if (status_q_i == ST_E) begin
            state_d     = S_RESP;
            status_we_d = 1'b1;
            status_n_d  = ST_M;
`endif
          end else begin
            state_d = S_ARB;
            msg_d   = MSG_INV;
          end
        end
      end
      S_ARB_WB: begin
        // Grant with done in the same cycle finishes the write-back at once.
        if (bus_gnt_i) begin
          state_d = bus_done_i ? S_ARB : S_BUS_WB;
        end
      end
      S_BUS_WB: begin
        if (bus_done_i) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (bus_gnt_i) begin
          if (bus_done_i) begin
            state_d     = S_RESP;
            status_we_d = 1'b1;
            status_n_d  = fill_state;
          end else begin
            state_d = S_BUS;
          end
        end else if ((msg_q == MSG_INV) && (status_q_i == ST_I)) begin
          // Line was snooped away before grant: upgrade becomes a write miss.
          msg_d = MSG_WM;
        end
      end
      S_BUS: begin
        if (bus_done_i) begin
          state_d     = S_RESP;
          status_we_d = 1'b1;
          status_n_d  = fill_state;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bus_req_d = (state_d == S_ARB_WB) || (state_d == S_BUS_WB) ||
                (state_d == S_ARB)    || (state_d == S_BUS);
    wb_d      = (state_d == S_ARB_WB) || (state_d == S_BUS_WB);
    ready_d   = (state_d == S_RESP);
    message_d = ((state_d == S_ARB) || (state_d == S_BUS)) ? msg_d : MSG_NA;
  end

endmodule

// File: tb/tb_cpu_mesi_requester.sv
// Testbench for cpu_mesi_requester: decode table, hand-written corner
// sequences (snoop race, dirty miss, reset in BUS, dropped request) and
// randomized transactions checked against a transaction-level model.
module tb_cpu_mesi_requester;

`ifdef MESI_SILENT_UPGRADE_EN
  localparam bit SILENT = 1'b1;
`else
  localparam bit SILENT = 1'b0;
`endif

  localparam logic [1:0] I = 2'b00, M = 2'b01, S = 2'b10, E = 2'b11;
  localparam logic [1:0] NA = 2'b00, INV = 2'b01, WM = 2'b10, RM = 2'b11;

  logic       clk, rst_n;
  logic       cpu_req, cpu_we, hit, bus_gnt, bus_done, bus_shared;
  logic [1:0] status_q;
  logic       cpu_ready, bus_req, wb, status_we;
  logic [1:0] message, status_n;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_mesi_requester #(.STATE_W(2), .MSG_W(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .hit_i        (hit),
    .status_q_i   (status_q),
    .bus_gnt_i    (bus_gnt),
    .bus_done_i   (bus_done),
    .bus_shared_i (bus_shared),
    .cpu_ready_o  (cpu_ready),
    .bus_req_o    (bus_req),
    .message_o    (message),
    .wb_o         (wb),
    .status_we_o  (status_we),
    .status_n_o   (status_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, cpu_ready, 0);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_msg"}, message, NA);
    chk({tag, "_wb"}, wb, 0);
    chk({tag, "_status_we"}, status_we, 0);
  endtask

  // One bus phase: arbitration gap, grant, then b cycles to done (b=0 means
  // grant and done together). msg tracks the expected coherence message.
  task automatic bus_phase(input bit is_wb, inout logic [1:0] msg,
                           input int gap, input int b, input int snoop_k,
                           input logic shared);
    for (int i = 0; i < gap; i++) begin
      chk("arb_req", bus_req, 1);
      chk("arb_wb", wb, is_wb);
      chk("arb_msg", message, is_wb ? NA : msg);
      bus_gnt    = 1'b0;
      bus_done   = 1'($urandom_range(0, 1));   // done without grant: ignored
      bus_shared = 1'($urandom_range(0, 1));
      if (!is_wb && i == snoop_k) status_q = I;
      tick();
      if (!is_wb && msg == INV && status_q == I) msg = WM;
    end
    chk("gnt_req", bus_req, 1);
    chk("gnt_wb", wb, is_wb);
    chk("gnt_msg", message, is_wb ? NA : msg);
    bus_gnt    = 1'b1;
    bus_done   = (b == 0);
    bus_shared = (b == 0) ? shared : 1'($urandom_range(0, 1));
    tick();
    bus_gnt = 1'b0;
    for (int j = 0; j < b; j++) begin
      chk("bus_req", bus_req, 1);
      chk("bus_wb", wb, is_wb);
      chk("bus_msg", message, is_wb ? NA : msg);
      bus_done   = (j == b - 1);
      bus_shared = (j == b - 1) ? shared : 1'($urandom_range(0, 1));
      tick();
    end
    bus_done = 1'b0;
  endtask

  // Full transaction from IDLE with a planned bus timing; expectations come
  // from the MESI request rules, not from the design.
  task automatic run_tx(input logic we_v, input logic hit_v, input logic [1:0] st,
                        input int gap_wb, input int b_wb, input int gap, input int b,
                        input logic shared, input int snoop_k);
    logic       miss, dirty, on_bus, upg;
    logic [1:0] msg, fin;
    miss   = !hit_v || st == I;
    dirty  = miss && st == M;
    on_bus = 1'b1;
    upg    = 1'b0;
    msg    = NA;
    if (!miss) begin
      if (!we_v || st == M) on_bus = 1'b0;
      else if (st == E && SILENT) begin on_bus = 1'b0; upg = 1'b1; end
      else msg = INV;
    end else begin
      msg = we_v ? WM : RM;
    end

    cpu_req = 1'b1; cpu_we = we_v; hit = hit_v; status_q = st;
    bus_gnt = 1'b0; bus_done = 1'b0;
    tick();
    if (!on_bus) begin
      chk("hit_ready", cpu_ready, 1);
      chk("hit_bus_req", bus_req, 0);
      chk("hit_status_we", status_we, upg);
      if (upg) chk("hit_status_n", status_n, M);
    end else begin
      if (dirty) bus_phase(1'b1, msg, gap_wb, b_wb, -1, shared);
      bus_phase(1'b0, msg, gap, b, snoop_k, shared);
      fin = (msg == RM) ? (shared ? S : E) : M;
      chk("resp_ready", cpu_ready, 1);
      chk("resp_bus_req", bus_req, 0);
      chk("resp_msg", message, NA);
      chk("resp_wb", wb, 0);
      chk("resp_status_we", status_we, 1);
      chk("resp_status_n", status_n, fin);
    end
    cpu_req = 1'b0;
    tick();
    chk_idle("post");
  endtask

  // Finish whatever transaction is open by granting and completing at once.
  task automatic drain();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (cpu_ready) seen = 1'b1;
      else begin bus_gnt = 1'b1; bus_done = 1'b1; tick(); end
    end
    bus_gnt = 1'b0; bus_done = 1'b0; cpu_req = 1'b0;
    chk("drain_done", seen, 1);
    tick();
  endtask

  typedef struct packed {
    logic       we;
    logic       hit;
    logic [1:0] st;
    logic       ready;
    logic       breq;
    logic       swe;
    logic [1:0] msg;
    logic       wb;
  } vec_t;

  function automatic vec_t mk(logic we_v, logic hit_v, logic [1:0] st, logic ready,
                              logic breq, logic swe, logic [1:0] msg, logic wb_v);
    vec_t v;
    v.we = we_v; v.hit = hit_v; v.st = st; v.ready = ready;
    v.breq = breq; v.swe = swe; v.msg = msg; v.wb = wb_v;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    // Response one cycle after a request seen in IDLE.
    tbl[0]  = mk(0, 1, S, 1, 0, 0, NA,  0);  // load hit S
    tbl[1]  = mk(0, 1, M, 1, 0, 0, NA,  0);  // load hit M
    tbl[2]  = mk(0, 1, E, 1, 0, 0, NA,  0);  // load hit E
    tbl[3]  = mk(1, 1, M, 1, 0, 0, NA,  0);  // store hit M
    tbl[4]  = SILENT ? mk(1, 1, E, 1, 0, 1, NA, 0)   // silent upgrade
                     : mk(1, 1, E, 0, 1, 0, INV, 0); // visible upgrade
    tbl[5]  = mk(1, 1, S, 0, 1, 0, INV, 0);  // store hit S
    tbl[6]  = mk(0, 1, I, 0, 1, 0, RM,  0);  // hit on invalid line
    tbl[7]  = mk(1, 0, S, 0, 1, 0, WM,  0);  // store miss, clean victim
    tbl[8]  = mk(0, 0, E, 0, 1, 0, RM,  0);  // load miss, clean victim
    tbl[9]  = mk(0, 0, M, 0, 1, 0, NA,  1);  // load miss, dirty victim
    tbl[10] = mk(1, 0, M, 0, 1, 0, NA,  1);  // store miss, dirty victim

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; hit = 1'b0; status_q = I;
    bus_gnt = 1'b0; bus_done = 1'b0; bus_shared = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_status_n", status_n, I);
    rst_n = 1'b1;
    tick();

    foreach (tbl[k]) begin
      cpu_req = 1'b1; cpu_we = tbl[k].we; hit = tbl[k].hit; status_q = tbl[k].st;
      tick();
      chk($sformatf("tbl%0d_ready", k), cpu_ready, tbl[k].ready);
      chk($sformatf("tbl%0d_bus_req", k), bus_req, tbl[k].breq);
      chk($sformatf("tbl%0d_msg", k), message, tbl[k].msg);
      chk($sformatf("tbl%0d_wb", k), wb, tbl[k].wb);
      chk($sformatf("tbl%0d_status_we", k), status_we, tbl[k].swe);
      if (tbl[k].swe) chk($sformatf("tbl%0d_status_n", k), status_n, M);
      drain();
    end

    // Load miss on invalid victim, not shared -> E, then shared -> S.
    run_tx(0, 0, I, 0, 0, 1, 2, 1'b0, -1);
    run_tx(0, 0, I, 0, 0, 0, 1, 1'b1, -1);
    // Store hit E: local or via invalidate depending on build.
    run_tx(1, 1, E, 0, 0, 2, 1, 1'b1, -1);
    // Store hit S, line snooped away before grant: INV -> WM, final M.
    run_tx(1, 1, S, 0, 0, 3, 1, 1'b1, 1);
    // Store miss with dirty victim: write-back then write miss.
    run_tx(1, 0, M, 2, 2, 1, 1, 1'b1, -1);
    // Grant and done in the same cycle on both phases.
    run_tx(0, 0, M, 0, 0, 0, 0, 1'b0, -1);

    // Reset asserted while in BUS clears outputs immediately.
    cpu_req = 1'b1; cpu_we = 1'b1; hit = 1'b0; status_q = S;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("pre_rst_bus_req", bus_req, 1);
    chk("pre_rst_msg", message, WM);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_status_n", status_n, I);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_tx(0, 1, S, 0, 0, 0, 0, 1'b0, -1);

    // Request dropped mid-transaction still completes.
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; status_q = I;
    tick();
    cpu_req = 1'b0; bus_gnt = 1'b1; bus_done = 1'b1; bus_shared = 1'b0;
    tick();
    bus_gnt = 1'b0; bus_done = 1'b0;
    chk("drop_ready", cpu_ready, 1);
    chk("drop_status_we", status_we, 1);
    chk("drop_status_n", status_n, E);
    tick();
    chk_idle("drop_post");

    // Randomized transactions.
    for (int r = 0; r < 150; r++) begin
      run_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
